// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register stage feeding the instruction-memory fetch port.
//
// Ports:
//   clk           - rising-edge system clock
//   reset         - asynchronous, active-high reset
//   pc_next_in    - redirect target from the PC-select mux
//   redirect      - mux select; 1 = take pc_next_in (branch/jump)
//   stall         - decode stall; blocks PC advance and drops imem_valid
//   imem_ready    - instruction memory accepts the request this cycle
//   imem_valid    - fetch request valid
//   pc_out        - current fetch address
//   pc_plus4      - pc_out + 4 (combinational), sequential input of the mux
//   misalign_trap - sticky trap flag, set on a misaligned target
//   trap_addr     - the misaligned target that caused the trap
//   fetch_count   - accepted-fetch counter
//
// Build option: define FETCH_COUNTER_EN to build the accepted-fetch counter;
// otherwise fetch_count is tied to zero.
module pc_fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_next_in,
    input  logic            redirect,
    input  logic            stall,
    input  logic            imem_ready,
    output logic            imem_valid,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misalign_trap,
    output logic [XLEN-1:0] trap_addr,
    output logic [31:0]     fetch_count
);
    localparam logic [1:0] HOLD  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] TRAP  = 2'd2;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_trap_addr;
    logic            r_pend_valid;
    logic [XLEN-1:0] r_pend_addr;
    logic            w_accept;
    logic [XLEN-1:0] w_target;
    logic            w_misalign;

    always_comb begin
        pc_plus4   = r_pc + {{(XLEN-3){1'b0}}, 3'd4};
        imem_valid = (r_state == FETCH) && !stall;
        w_accept   = imem_valid && imem_ready;
        // A live redirect outranks an older pending one, which outranks sequential flow.
        w_target   = redirect ? pc_next_in : (r_pend_valid ? r_pend_addr : pc_plus4);
        w_misalign = |w_target[1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= HOLD;
            r_pc         <= RESET_VECTOR;
            r_trap_addr  <= '0;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
        end else begin
            case (r_state)
                HOLD:    r_state <= FETCH;
                FETCH: begin
                    if (w_accept) begin
                        r_pend_valid <= 1'b0;
                        if (w_misalign) begin
                            r_trap_addr <= w_target;
                            r_state     <= TRAP;
                        end else begin
                            r_pc <= w_target;
                        end
                    end else if (redirect) begin
                        // No accept this cycle: park the target until the next accept.
                        r_pend_valid <= 1'b1;
                        r_pend_addr  <= pc_next_in;
                    end
                end
                default: r_state <= TRAP;
            endcase
        end
    end

`ifdef FETCH_COUNTER_EN
    logic [31:0] r_fetch_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_fetch_count <= '0;
        else if (w_accept)
            r_fetch_count <= r_fetch_count + 32'd1;
    end

    assign fetch_count = r_fetch_count;
`else
    assign fetch_count = 32'h0;
`endif

    assign pc_out        = r_pc;
    assign trap_addr     = r_trap_addr;
    assign misalign_trap = (r_state == TRAP);
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: table-driven directed test of pc_fetch_unit plus reset and trap sequences.
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_next_in = '0;
    logic        redirect = 1'b0;
    logic        stall = 1'b0;
    logic        imem_ready = 1'b0;
    logic        imem_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        misalign_trap;
    logic [31:0] trap_addr;
    logic [31:0] fetch_count;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;

    typedef struct {
        logic        st;
        logic        rdy;
        logic        rd;
        logic [31:0] nxt;
        logic        ev;
        logic [31:0] epc;
        logic        etr;
        logic [31:0] eta;
    } vec_t;

    vec_t vecs[21];

    pc_fetch_unit dut (
        .clk(clk), .reset(reset), .pc_next_in(pc_next_in), .redirect(redirect),
        .stall(stall), .imem_ready(imem_ready), .imem_valid(imem_valid),
        .pc_out(pc_out), .pc_plus4(pc_plus4), .misalign_trap(misalign_trap),
        .trap_addr(trap_addr), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic rdy, input logic rd, input logic [31:0] nxt,
                                input logic ev, input logic [31:0] epc, input logic etr, input logic [31:0] eta);
        vec_t v;
        v.st = st; v.rdy = rdy; v.rd = rd; v.nxt = nxt;
        v.ev = ev; v.epc = epc; v.etr = etr; v.eta = eta;
        return v;
    endfunction

    function automatic logic [31:0] fc_exp(input int n);
`ifdef FETCH_COUNTER_EN
        return 32'(n);
`else
        return 32'(n) & 32'h0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        stall = v.st; imem_ready = v.rdy; redirect = v.rd; pc_next_in = v.nxt;
        #1;
        chk("imem_valid", 32'(imem_valid), 32'(v.ev));
        chk("pc_out", pc_out, v.epc);
        chk("pc_plus4", pc_plus4, v.epc + 32'd4);
        chk("misalign_trap", 32'(misalign_trap), 32'(v.etr));
        chk("trap_addr", trap_addr, v.eta);
        chk("fetch_count", fetch_count, fc_exp(n_acc));
        if (v.ev && v.rdy) n_acc++;
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_pc"}, pc_out, 32'h0);
        chk({nm, "_plus4"}, pc_plus4, 32'h4);
        chk({nm, "_valid"}, 32'(imem_valid), 32'h0);
        chk({nm, "_trap"}, 32'(misalign_trap), 32'h0);
        chk({nm, "_taddr"}, trap_addr, 32'h0);
        chk({nm, "_fc"}, fetch_count, 32'h0);
    endtask

    initial begin
        vecs[0]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
        vecs[1]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0);
        vecs[2]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0);
        vecs[3]  = mk(1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h8,   1'b0, 32'h0);
        vecs[4]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0);
        vecs[5]  = mk(1'b0, 1'b1, 1'b1, 32'h10,  1'b1, 32'h104, 1'b0, 32'h0);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'h0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h10,  1'b0, 32'h0);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'h0);
        vecs[9]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'h0);
        vecs[10] = mk(1'b0, 1'b1, 1'b1, 32'h20,  1'b1, 32'h200, 1'b0, 32'h0);
        vecs[11] = mk(1'b1, 1'b1, 1'b1, 32'h300, 1'b0, 32'h20,  1'b0, 32'h0);
        vecs[12] = mk(1'b1, 1'b1, 1'b1, 32'h400, 1'b0, 32'h20,  1'b0, 32'h0);
        vecs[13] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h20,  1'b0, 32'h0);
        vecs[14] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h400, 1'b0, 32'h0);
        vecs[15] = mk(1'b0, 1'b0, 1'b1, 32'h600, 1'b1, 32'h404, 1'b0, 32'h0);
        vecs[16] = mk(1'b0, 1'b1, 1'b1, 32'h700, 1'b1, 32'h404, 1'b0, 32'h0);
        vecs[17] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h700, 1'b0, 32'h0);
        vecs[18] = mk(1'b0, 1'b1, 1'b1, 32'h102, 1'b1, 32'h704, 1'b0, 32'h0);
        vecs[19] = mk(1'b0, 1'b1, 1'b1, 32'h500, 1'b0, 32'h704, 1'b1, 32'h102);
        vecs[20] = mk(1'b1, 1'b1, 1'b1, 32'h500, 1'b0, 32'h704, 1'b1, 32'h102);

        #1 reset = 1'b1;
        #1 chk_reset_state("por");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 21; i++) begin
            if (i > 0) @(negedge clk);
            run_vec(vecs[i]);
        end

        // Reset mid-cycle from TRAP, then wrap-around and counter sequence.
        @(posedge clk);
        #2 reset = 1'b1;
        n_acc = 0;
        #1 chk_reset_state("rst_trap");
        @(negedge clk);
        reset = 1'b0;
        run_vec(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0));
        @(negedge clk) run_vec(mk(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0, 1'b0, 32'h0));
        @(negedge clk) run_vec(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0));
        @(negedge clk) run_vec(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0));
        @(negedge clk) run_vec(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4, 1'b0, 32'h0));
        @(negedge clk) run_vec(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8, 1'b0, 32'h0));
        @(posedge clk);
        #1;
        chk("fc_five", fetch_count, fc_exp(5));
        chk("pc_five", pc_out, 32'hC);
        #1 reset = 1'b1;
        n_acc = 0;
        #1 chk_reset_state("rst_fetch");

        // Misaligned pending target traps when it is finally loaded.
        @(negedge clk);
        reset = 1'b0;
        run_vec(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0));
        @(negedge clk) run_vec(mk(1'b0, 1'b0, 1'b1, 32'h201, 1'b1, 32'h0, 1'b0, 32'h0));
        @(negedge clk) run_vec(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0));
        @(negedge clk) run_vec(mk(1'b0, 1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 1'b1, 32'h201));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
